rv_ex_arith_unit: RTL and testbench
===================================

Name: rv_ex_arith_unit

Overview:
- Execute-stage arithmetic block for the RV32I 5-stage pipeline.
- Combines three functions: the ALU control decoder, the 32-bit ALU with zero flag, and two 32-bit adders (PC+4 and PC+immediate branch/jump target).
- All primary outputs are combinational for same-cycle use by PC select and forwarding.
- An enable-gated output register holds the last result for the EX/MEM boundary.

Parameters:
- XLEN, 32, datapath width. Only 32 is required.

Ports:
- clk  input  1  clock; rising edge.
- reset  input  1  reset, synchronous, active-low.
- en  input  1  capture enable for the registered outputs.
- alu_op  input  2  ALU operation class from the main control unit.
- funct3  input  3  instruction bits [14:12].
- funct7b5  input  1  instruction bit 30.
- op_b5  input  1  opcode bit 5. 1 means R-type, 0 means I-type ALU.
- src_a  input  32  ALU operand A, after forwarding.
- src_b  input  32  ALU operand B, after forwarding and immediate select.
- pc  input  32  PC of the instruction in execute.
- imm  input  32  sign-extended immediate.
- alu_control  output  4  decoded ALU operation.
- alu_result  output  32  combinational ALU result.
- zero  output  1  1 when alu_result == 0.
- pc_plus4  output  32  pc + 4.
- pc_target  output  32  pc + imm.
- alu_result_q  output  32  registered alu_result.
- zero_q  output  1  registered zero.
- pc_target_q  output  32  registered pc_target.

Behaviour:
- Decoder (combinational):
  - alu_op=00 → ADD (0000).
  - alu_op=01 → SUB (0001).
  - alu_op=11 → ADD.
  - alu_op=10 → decode funct3:
    - 000 → SUB if funct7b5 & op_b5, else ADD.
    - 001 → SLL (0111).
    - 010 → SLT (0101).
    - 011 → SLTU (0110).
    - 100 → XOR (0100).
    - 101 → SRA (1001) if funct7b5, else SRL (1000).
    - 110 → OR (0011).
    - 111 → AND (0010).
- ALU (combinational), by alu_control:
  - ADD: a+b, modulo 2^32. SUB: a−b, modulo 2^32. No overflow or carry outputs.
  - AND, OR, XOR: bitwise.
  - SLT: 1 if signed a<b, else 0, zero-extended.
  - SLTU: same compare, unsigned.
  - SLL, SRL, SRA: shift amount is src_b[4:0]; src_b[31:5] is ignored. SRA replicates bit 31.
  - Codes 1010–1111: result 0.
- zero: 1 when alu_result == 0, for any operation.
- Adders: pc_plus4 and pc_target are plain 32-bit sums; carry-out is discarded (0xFFFFFFFC+4 = 0).
- Registered outputs, updated at rising clk:
  - reset=0: alu_result_q=0, zero_q=0, pc_target_q=0. Reset overrides en.
  - reset=1, en=1: capture alu_result, zero, pc_target.
  - reset=1, en=0: hold previous values.
  - Reset asserted mid-operation clears the registers on the next edge. Combinational outputs are unaffected by reset.
- Latency:
  - Combinational outputs: 0 cycles, no X when inputs are known.
  - Registered outputs: 1 cycle.
- No handshake and no internal state other than the output registers.

Test Plan:
- Decode and add/sub: alu_op=10, funct3=000, funct7b5=1, op_b5=1, a=5, b=7.
  - Required: alu_control=0001, alu_result=0xFFFFFFFE, zero=0.
  - Same inputs with op_b5=0: ADD, alu_result=12.
- Branch compare: alu_op=01, a=b=0x12345678 → alu_result=0, zero=1.
  - a=0x80000000, b=1: result 0x7FFFFFFF, zero=0.
- Compares: SLT with a=0xFFFFFFFF, b=1 → 1.
  - SLTU with the same operands → 0.
  - AND 0xF0F0F0F0 & 0x0FF00FF0 → 0x00F000F0.
- Shifts: a=0x80000001, b=0x00000021 (shamt 1).
  - SLL → 0x00000002.
  - SRL → 0x40000000.
  - SRA → 0xC0000000.
- Adders: pc=0x000000CC, imm=0xFFFFFFF0.
  - Required: pc_plus4=0x000000D0, pc_target=0x000000BC.
  - Wrap case: pc=0xFFFFFFFC → pc_plus4=0.
- Register sequencing:
  - Hold reset=0 for 2 cycles → all _q outputs 0.
  - Release reset with en=1 and ADD 3+4 → alu_result_q=7 after one edge.
  - en=0 with new inputs → alu_result_q stays 7.
  - reset=0 together with en=1 → alu_result_q=0 after the next edge.

Source files
------------

// File: rtl/rv_ex_arith_unit_if.sv
// Execute-stage arithmetic bus: operands, decode fields and all results.
// slave = the arithmetic unit, master = whoever drives the execute stage.
interface rv_ex_arith_unit_if #(
   parameter int XLEN = 32
);
   logic            i_en;
   logic [1:0]      i_alu_op;
   logic [2:0]      i_funct3;
   logic            i_funct7b5;
   logic            i_op_b5;
   logic [XLEN-1:0] i_src_a;
   logic [XLEN-1:0] i_src_b;
   logic [XLEN-1:0] i_pc;
   logic [XLEN-1:0] i_imm;

   logic [3:0]      o_alu_control;
   logic [XLEN-1:0] o_alu_result;
   logic            o_zero;
   logic [XLEN-1:0] o_pc_plus4;
   logic [XLEN-1:0] o_pc_target;
   logic [XLEN-1:0] o_alu_result_q;
   logic            o_zero_q;
   logic [XLEN-1:0] o_pc_target_q;

   modport slave (
      input  i_en, i_alu_op, i_funct3, i_funct7b5, i_op_b5,
             i_src_a, i_src_b, i_pc, i_imm,
      output o_alu_control, o_alu_result, o_zero, o_pc_plus4, o_pc_target,
             o_alu_result_q, o_zero_q, o_pc_target_q
   );

   modport master (
      output i_en, i_alu_op, i_funct3, i_funct7b5, i_op_b5,
             i_src_a, i_src_b, i_pc, i_imm,
      input  o_alu_control, o_alu_result, o_zero, o_pc_plus4, o_pc_target,
             o_alu_result_q, o_zero_q, o_pc_target_q
   );
endinterface

// File: rtl/rv_ex_arith_unit.sv
// RV32I execute-stage arithmetic: ALU control decode, ALU with zero flag,
// PC+4 and PC+imm adders. All results are combinational for same-cycle use;
// an enable-gated register holds ALU result, zero and target for EX/MEM.
module rv_ex_arith_unit #(
   parameter int XLEN = 32
) (
   input logic             clk,
   input logic             reset,
   rv_ex_arith_unit_if.slave bus
);

   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_SUB  = 4'b0001;
   localparam logic [3:0] ALU_AND  = 4'b0010;
   localparam logic [3:0] ALU_OR   = 4'b0011;
   localparam logic [3:0] ALU_XOR  = 4'b0100;
   localparam logic [3:0] ALU_SLT  = 4'b0101;
   localparam logic [3:0] ALU_SLTU = 4'b0110;
   localparam logic [3:0] ALU_SLL  = 4'b0111;
   localparam logic [3:0] ALU_SRL  = 4'b1000;
   localparam logic [3:0] ALU_SRA  = 4'b1001;

   localparam logic [XLEN-1:0] C_FOUR = XLEN'(4);

   logic [3:0]      w_alu_control;
   logic [XLEN-1:0] w_alu_result;
   logic            w_zero;
   logic [XLEN-1:0] w_pc_plus4;
   logic [XLEN-1:0] w_pc_target;
   logic [4:0]      w_shamt;
   logic            w_lt_signed;
   logic            w_lt_unsigned;

   logic [XLEN-1:0] r_alu_result_q;
   logic            r_zero_q;
   logic [XLEN-1:0] r_pc_target_q;

   // Decode the main-control op class plus funct fields into an ALU operation.
   // The SUB/ADD split on funct3=000 needs op_b5 so that ADDI with a
   // negative immediate (imm bit 30 set) is not mistaken for SUB.
   always_comb begin
      w_alu_control = ALU_ADD;
      unique case (bus.i_alu_op)
         2'b00: w_alu_control = ALU_ADD;
         2'b01: w_alu_control = ALU_SUB;
         2'b11: w_alu_control = ALU_ADD;
         default: begin
            unique case (bus.i_funct3)
               3'b000:  w_alu_control = (bus.i_funct7b5 & bus.i_op_b5) ? ALU_SUB : ALU_ADD;
               3'b001:  w_alu_control = ALU_SLL;
               3'b010:  w_alu_control = ALU_SLT;
               3'b011:  w_alu_control = ALU_SLTU;
               3'b100:  w_alu_control = ALU_XOR;
               3'b101:  w_alu_control = bus.i_funct7b5 ? ALU_SRA : ALU_SRL;
               3'b110:  w_alu_control = ALU_OR;
               default: w_alu_control = ALU_AND;
            endcase
         end
      endcase
   end

   assign w_shamt       = bus.i_src_b[4:0];
   assign w_lt_signed   = $signed(bus.i_src_a) < $signed(bus.i_src_b);
   assign w_lt_unsigned = bus.i_src_a < bus.i_src_b;

   // ALU datapath; unused operation codes produce zero.
   always_comb begin
      w_alu_result = '0;
      case (w_alu_control)
         ALU_ADD:  w_alu_result = bus.i_src_a + bus.i_src_b;
         ALU_SUB:  w_alu_result = bus.i_src_a - bus.i_src_b;
         ALU_AND:  w_alu_result = bus.i_src_a & bus.i_src_b;
         ALU_OR:   w_alu_result = bus.i_src_a | bus.i_src_b;
         ALU_XOR:  w_alu_result = bus.i_src_a ^ bus.i_src_b;
         ALU_SLT:  w_alu_result = {{(XLEN-1){1'b0}}, w_lt_signed};
         ALU_SLTU: w_alu_result = {{(XLEN-1){1'b0}}, w_lt_unsigned};
         ALU_SLL:  w_alu_result = bus.i_src_a << w_shamt;
         ALU_SRL:  w_alu_result = bus.i_src_a >> w_shamt;
         ALU_SRA:  w_alu_result = XLEN'($signed(bus.i_src_a) >>> w_shamt);
         default:  w_alu_result = '0;
      endcase
   end

   assign w_zero      = (w_alu_result == '0);
   assign w_pc_plus4  = bus.i_pc + C_FOUR;
   assign w_pc_target = bus.i_pc + bus.i_imm;

   // EX/MEM capture register: synchronous active-low reset wins over enable.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_alu_result_q <= '0;
         r_zero_q       <= 1'b0;
         r_pc_target_q  <= '0;
      end else if (bus.i_en) begin
         r_alu_result_q <= w_alu_result;
         r_zero_q       <= w_zero;
         r_pc_target_q  <= w_pc_target;
      end
   end

   assign bus.o_alu_control  = w_alu_control;
   assign bus.o_alu_result   = w_alu_result;
   assign bus.o_zero         = w_zero;
   assign bus.o_pc_plus4     = w_pc_plus4;
   assign bus.o_pc_target    = w_pc_target;
   assign bus.o_alu_result_q = r_alu_result_q;
   assign bus.o_zero_q       = r_zero_q;
   assign bus.o_pc_target_q  = r_pc_target_q;

endmodule

// File: tb/tb_rv_ex_arith_unit.sv
// Bench for rv_ex_arith_unit: expected results are queued when stimulus is
// driven and popped when the combinational or registered outputs are sampled.
module tb_rv_ex_arith_unit;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   rv_ex_arith_unit_if #(.XLEN(32)) u_if ();

   rv_ex_arith_unit #(.XLEN(32)) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (u_if.slave)
   );

   typedef struct {
      logic [3:0]  ctrl;
      logic [31:0] res;
      logic        zero;
      logic [31:0] p4;
      logic [31:0] tgt;
   } comb_exp_t;

   typedef struct {
      logic [31:0] res;
      logic        zero;
      logic [31:0] tgt;
   } reg_exp_t;

   comb_exp_t q_comb[$];
   reg_exp_t  q_reg[$];

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference decode, written straight from the operation table.
   function automatic logic [3:0] ref_ctrl(input logic [1:0] op, input logic [2:0] f3,
                                           input logic f7, input logic ob5);
      if (op == 2'b01) return 4'b0001;
      if (op != 2'b10) return 4'b0000;
      case (f3)
         3'b000: return (f7 && ob5) ? 4'b0001 : 4'b0000;
         3'b001: return 4'b0111;
         3'b010: return 4'b0101;
         3'b011: return 4'b0110;
         3'b100: return 4'b0100;
         3'b101: return f7 ? 4'b1001 : 4'b1000;
         3'b110: return 4'b0011;
         default: return 4'b0010;
      endcase
   endfunction

   // Reference ALU using bit-serial shifts and sign-bit compare logic.
   function automatic logic [31:0] ref_alu(input logic [3:0] c, input logic [31:0] a,
                                           input logic [31:0] b);
      logic [31:0] t;
      t = a;
      case (c)
         4'b0000: return a + b;
         4'b0001: return a + ~b + 32'd1;
         4'b0010: return a & b;
         4'b0011: return a | b;
         4'b0100: return a ^ b;
         4'b0101: return (a[31] != b[31]) ? {31'd0, a[31]} : {31'd0, (a < b)};
         4'b0110: return {31'd0, (a < b)};
         4'b0111: begin for (int i = 0; i < int'(b[4:0]); i++) t = {t[30:0], 1'b0}; return t; end
         4'b1000: begin for (int i = 0; i < int'(b[4:0]); i++) t = {1'b0, t[31:1]}; return t; end
         4'b1001: begin for (int i = 0; i < int'(b[4:0]); i++) t = {t[31], t[31:1]}; return t; end
         default: return 32'd0;
      endcase
   endfunction

   task automatic drive(input logic [1:0] op, input logic [2:0] f3, input logic f7,
                        input logic ob5, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] pc, input logic [31:0] imm,
                        input logic [3:0] exp_ctrl, input logic [31:0] exp_res);
      comb_exp_t e;
      @(negedge clk);
      u_if.i_alu_op   = op;
      u_if.i_funct3   = f3;
      u_if.i_funct7b5 = f7;
      u_if.i_op_b5    = ob5;
      u_if.i_src_a    = a;
      u_if.i_src_b    = b;
      u_if.i_pc       = pc;
      u_if.i_imm      = imm;
      e.ctrl = exp_ctrl;
      e.res  = exp_res;
      e.zero = (exp_res == 32'd0);
      e.p4   = pc + 32'd4;
      e.tgt  = pc + imm;
      q_comb.push_back(e);
   endtask

   task automatic check_comb(input string tag);
      comb_exp_t e;
      #1;
      if (q_comb.size() == 0) begin
         check({tag, "_queue_empty"}, 32'd0, 32'd1);
         return;
      end
      e = q_comb.pop_front();
      check({tag, "_ctrl"},  {28'd0, u_if.o_alu_control}, {28'd0, e.ctrl});
      check({tag, "_res"},   u_if.o_alu_result, e.res);
      check({tag, "_zero"},  {31'd0, u_if.o_zero}, {31'd0, e.zero});
      check({tag, "_p4"},    u_if.o_pc_plus4, e.p4);
      check({tag, "_tgt"},   u_if.o_pc_target, e.tgt);
   endtask

   task automatic push_reg(input logic [31:0] res, input logic zero, input logic [31:0] tgt);
      reg_exp_t e;
      e.res = res; e.zero = zero; e.tgt = tgt;
      q_reg.push_back(e);
   endtask

   task automatic check_reg(input string tag);
      reg_exp_t e;
      @(posedge clk);
      #1;
      if (q_reg.size() == 0) begin
         check({tag, "_queue_empty"}, 32'd0, 32'd1);
         return;
      end
      e = q_reg.pop_front();
      check({tag, "_res_q"},  u_if.o_alu_result_q, e.res);
      check({tag, "_zero_q"}, {31'd0, u_if.o_zero_q}, {31'd0, e.zero});
      check({tag, "_tgt_q"},  u_if.o_pc_target_q, e.tgt);
   endtask

   initial begin
      logic [1:0]  op;
      logic [2:0]  f3;
      logic        f7, ob5;
      logic [31:0] a, b, pc, imm, r;
      logic [3:0]  c;

      reset = 1'b0;
      u_if.i_en       = 1'b1;
      u_if.i_alu_op   = 2'b00;
      u_if.i_funct3   = 3'b000;
      u_if.i_funct7b5 = 1'b0;
      u_if.i_op_b5    = 1'b0;
      u_if.i_src_a    = 32'h11;
      u_if.i_src_b    = 32'h22;
      u_if.i_pc       = 32'h40;
      u_if.i_imm      = 32'h8;

      // Reset held two cycles with en=1 and live inputs: registers stay clear.
      push_reg(32'd0, 1'b0, 32'd0);
      check_reg("rst_c1");
      push_reg(32'd0, 1'b0, 32'd0);
      check_reg("rst_c2");

      // Combinational path does not care about reset.
      drive(2'b10, 3'b000, 1'b1, 1'b1, 32'd5, 32'd7, 32'h0, 32'h0, 4'b0001, 32'hFFFF_FFFE);
      check_comb("sub_in_rst");

      // Release reset with ADD 3+4 and capture.
      @(negedge clk);
      reset = 1'b1;
      u_if.i_en = 1'b1;
      drive(2'b00, 3'b000, 1'b0, 1'b0, 32'd3, 32'd4, 32'h100, 32'h20, 4'b0000, 32'd7);
      check_comb("add34");
      push_reg(32'd7, 1'b0, 32'h120);
      check_reg("cap_add34");

      // en=0: new inputs, registers hold.
      u_if.i_en = 1'b0;
      drive(2'b01, 3'b000, 1'b0, 1'b0, 32'd9, 32'd9, 32'h200, 32'h4, 4'b0001, 32'd0);
      check_comb("sub99");
      push_reg(32'd7, 1'b0, 32'h120);
      check_reg("hold");

      // Reset together with en=1 clears on the next edge.
      reset = 1'b0;
      u_if.i_en = 1'b1;
      push_reg(32'd0, 1'b0, 32'd0);
      check_reg("rst_over_en");

      reset = 1'b1;
      u_if.i_en = 1'b0;

      drive(2'b10, 3'b000, 1'b1, 1'b1, 32'd5, 32'd7, 32'hCC, 32'hFFFF_FFF0, 4'b0001, 32'hFFFF_FFFE);
      check_comb("rsub");
      drive(2'b10, 3'b000, 1'b1, 1'b0, 32'd5, 32'd7, 32'hFFFF_FFFC, 32'd8, 4'b0000, 32'd12);
      check_comb("addi_wrap");
      drive(2'b01, 3'b111, 1'b1, 1'b1, 32'h1234_5678, 32'h1234_5678, 32'h0, 32'h0, 4'b0001, 32'd0);
      check_comb("beq");
      drive(2'b01, 3'b000, 1'b0, 1'b0, 32'h8000_0000, 32'd1, 32'h10, 32'h10, 4'b0001, 32'h7FFF_FFFF);
      check_comb("sub_ovf");
      drive(2'b10, 3'b010, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd1, 32'h0, 32'h0, 4'b0101, 32'd1);
      check_comb("slt");
      drive(2'b10, 3'b011, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd1, 32'h0, 32'h0, 4'b0110, 32'd0);
      check_comb("sltu");
      drive(2'b10, 3'b111, 1'b0, 1'b1, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h0, 32'h0, 4'b0010, 32'h00F0_00F0);
      check_comb("and");
      drive(2'b10, 3'b110, 1'b0, 1'b1, 32'hF0F0_0000, 32'h0000_0F0F, 32'h0, 32'h0, 4'b0011, 32'hF0F0_0F0F);
      check_comb("or");
      drive(2'b10, 3'b100, 1'b0, 1'b1, 32'hFFFF_0000, 32'hFF00_FF00, 32'h0, 32'h0, 4'b0100, 32'h00FF_FF00);
      check_comb("xor");
      drive(2'b10, 3'b001, 1'b0, 1'b1, 32'h8000_0001, 32'h0000_0021, 32'h0, 32'h0, 4'b0111, 32'h0000_0002);
      check_comb("sll");
      drive(2'b10, 3'b101, 1'b0, 1'b1, 32'h8000_0001, 32'h0000_0021, 32'h0, 32'h0, 4'b1000, 32'h4000_0000);
      check_comb("srl");
      drive(2'b10, 3'b101, 1'b1, 1'b1, 32'h8000_0001, 32'h0000_0021, 32'h0, 32'h0, 4'b1001, 32'hC000_0000);
      check_comb("sra");
      drive(2'b11, 3'b101, 1'b1, 1'b1, 32'd100, 32'hFFFF_FF9C, 32'h0, 32'h0, 4'b0000, 32'd0);
      check_comb("jalr_add");

      // Randomised vectors captured through the register.
      u_if.i_en = 1'b1;
      for (int k = 0; k < 60; k++) begin
         op  = 2'($urandom_range(0, 3));
         f3  = 3'($urandom_range(0, 7));
         f7  = 1'($urandom_range(0, 1));
         ob5 = 1'($urandom_range(0, 1));
         a   = $urandom();
         b   = (k % 4 == 0) ? a : $urandom();
         pc  = $urandom();
         imm = $urandom();
         c   = ref_ctrl(op, f3, f7, ob5);
         r   = ref_alu(c, a, b);
         drive(op, f3, f7, ob5, a, b, pc, imm, c, r);
         check_comb("rnd");
         push_reg(r, (r == 32'd0), pc + imm);
         check_reg("rnd");
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
